// File: rtl/mvc_pkg.sv
// Shared types and helpers for the tiled matrix-vector controller.
package mvc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WB,
    DRAIN
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  function automatic int unsigned ceil_div(
    input int unsigned a,
    input int unsigned b
  );
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned dly_total(
    input int unsigned m,
    input int unsigned a,
    input int unsigned s,
    input int unsigned c
  );
    return 1 + m + a * s + c;
  endfunction

endpackage

// File: rtl/mvc_tag_pipe.sv
// Fixed-latency tag delay line tracking tiles through the MAC datapath.
import mvc_pkg::*;

module mvc_tag_pipe #(
  parameter int DEPTH = 84
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  tag_t din,
  output tag_t dout,
  output logic any
);

  tag_t q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      q[0] <= din;
      for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
    end
  end

  always_comb begin
    any = 1'b0;
    for (int i = 0; i < DEPTH; i++) any = any | q[i].valid;
  end

  assign dout = q[DEPTH-1];

endmodule

// File: rtl/mv_tile_ctrl.sv
// Tiled matrix-vector multiply sequencer with stall-based writeback.
// Define MVC_PERF_EN to add the perf_cycles / perf_stalls counters.
import mvc_pkg::*;

module mv_tile_ctrl #(
  parameter int LANES      = 6,
  parameter int DIM_W      = 9,
  parameter int MADDR_W    = 12,
  parameter int VADDR_W    = 10,
  parameter int VOUT_BASE  = 512,
  parameter int DELAY_MUL  = 9,
  parameter int DELAY_ADD  = 12,
  parameter int ADD_STAGES = 3,
  parameter int DELAY_ACC  = 38
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DIM_W-1:0]   rows,
  input  logic [DIM_W-1:0]   cols,
  output logic               busy,
  output logic               done,
  output logic               mbram_en,
  output logic [MADDR_W-1:0] mbram_addr,
  output logic               vbram_en,
  output logic               vbram_we,
  output logic [VADDR_W-1:0] vbram_addr,
  output logic               zero_in,
  output logic               last,
  output logic               rows_done
`ifdef MVC_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_stalls
`endif
);

  localparam int DLY =
    dly_total(DELAY_MUL, DELAY_ADD, ADD_STAGES, DELAY_ACC);
  localparam int CW = 2 * DIM_W;

  state_t           state;
  logic [DIM_W-1:0] tpr;
  logic [DIM_W-1:0] nrb;
  logic [DIM_W-1:0] t;
  logic [DIM_W-1:0] wr_idx;
  logic [CW-1:0]    tile;
  logic [CW-1:0]    total;
  logic             all_issued;
  logic             issue;
  logic             write;
  logic             t_end;
  logic             tile_end;
  logic             inflight;
  logic             pipe_any;
  tag_t             ent;
  tag_t             ext;

  assign total    = CW'(tpr) * CW'(nrb);
  assign issue    = state == ISSUE;
  assign write    = (state == WB) && !abort;
  assign t_end    = t == tpr - 1'b1;
  assign tile_end = tile == total - 1'b1;
  assign inflight = ent.valid | pipe_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tpr        <= '0;
      nrb        <= '0;
      t          <= '0;
      tile       <= '0;
      wr_idx     <= '0;
      all_issued <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (rows == '0 || cols == '0) begin
                done <= 1'b1;
              end else begin
                state      <= ISSUE;
                tpr        <= DIM_W'(ceil_div(32'(cols), LANES));
                nrb        <= DIM_W'(ceil_div(32'(rows), LANES));
                t          <= '0;
                tile       <= '0;
                wr_idx     <= '0;
                all_issued <= 1'b0;
              end
            end
          end
          ISSUE: begin
            if (tile_end) all_issued <= 1'b1;
            else tile <= tile + 1'b1;
            t <= t_end ? '0 : t + 1'b1;
            if (rows_done) state <= WB;
            else if (tile_end) state <= DRAIN;
          end
          WB: begin
            wr_idx <= wr_idx + 1'b1;
            if (rows_done) begin
              state <= WB;
            end else if (!all_issued) begin
              state <= ISSUE;
            end else if (!inflight) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (rows_done) begin
              state <= WB;
            end else if (!inflight) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Tag is registered so it lines up with BRAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent <= '0;
    end else if (abort) begin
      ent <= '0;
    end else begin
      ent.valid <= issue;
      ent.last  <= issue && t_end;
    end
  end

  mvc_tag_pipe #(
    .DEPTH(DLY)
  ) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .flush(abort),
    .din  (ent),
    .dout (ext),
    .any  (pipe_any)
  );

  assign busy       = state != IDLE;
  assign mbram_en   = issue;
  assign mbram_addr = MADDR_W'(tile);
  assign vbram_we   = write;
  assign vbram_en   = issue | write;
  assign vbram_addr = write
    ? VADDR_W'(VOUT_BASE) + VADDR_W'(wr_idx)
    : VADDR_W'(t);
  assign zero_in    = ~ent.valid;
  assign last       = ent.last;
  assign rows_done  = ext.valid & ext.last;

`ifdef MVC_PERF_EN
  // The done cycle is counted so the total covers start to completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == IDLE && start && !abort) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy || done) perf_cycles <= perf_cycles + 1'b1;
      if (state == WB && !all_issued) perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mv_tile_ctrl.sv
// Directed + randomized bench for mv_tile_ctrl against a schedule model.
module tb_mv_tile_ctrl;

  localparam int MW = 12;
  localparam int VW = 10;
  localparam int DW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic abort0 = 1'b0, abort1 = 1'b0;
  logic [DW-1:0] rows = '0, cols = '0;

  logic busy0, done0, mben0, vben0, vwe0, zero0, last0, rd0;
  logic busy1, done1, mben1, vben1, vwe1, zero1, last1, rd1;
  logic [MW-1:0] maddr0, maddr1;
  logic [VW-1:0] vaddr0, vaddr1;
`ifdef MVC_PERF_EN
  logic [31:0] pc0, ps0, pc1, ps1;
`endif

  always #5 clk = ~clk;

  mv_tile_ctrl u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .rows(rows), .cols(cols), .busy(busy0), .done(done0),
    .mbram_en(mben0), .mbram_addr(maddr0),
    .vbram_en(vben0), .vbram_we(vwe0), .vbram_addr(vaddr0),
    .zero_in(zero0), .last(last0), .rows_done(rd0)
`ifdef MVC_PERF_EN
    , .perf_cycles(pc0), .perf_stalls(ps0)
`endif
  );

  mv_tile_ctrl #(
    .DELAY_MUL(1), .DELAY_ADD(1), .ADD_STAGES(1), .DELAY_ACC(1)
  ) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .rows(rows), .cols(cols), .busy(busy1), .done(done1),
    .mbram_en(mben1), .mbram_addr(maddr1),
    .vbram_en(vben1), .vbram_we(vwe1), .vbram_addr(vaddr1),
    .zero_in(zero1), .last(last1), .rows_done(rd1)
`ifdef MVC_PERF_EN
    , .perf_cycles(pc1), .perf_stalls(ps1)
`endif
  );

  logic sel = 1'b0;
  logic m_busy, m_done, m_mben, m_vben, m_vwe, m_zero, m_last;
  logic [MW-1:0] m_maddr;
  logic [VW-1:0] m_vaddr;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;
  assign m_mben  = sel ? mben1  : mben0;
  assign m_vben  = sel ? vben1  : vben0;
  assign m_vwe   = sel ? vwe1   : vwe0;
  assign m_zero  = sel ? zero1  : zero0;
  assign m_last  = sel ? last1  : last0;
  assign m_maddr = sel ? maddr1 : maddr0;
  assign m_vaddr = sel ? vaddr1 : vaddr0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int c0 = 0;

  logic [MW-1:0] rd_m[$];
  logic [VW-1:0] rd_v[$];
  logic [VW-1:0] wr_a[$];
  int wr_c[$];
  int last_idx[$];
  int ndata, ndone, done_c, bad;
  bit busy_seen, en_seen;

  int exp_wc[$];
  int exp_stalls, exp_t, exp_tpr, exp_nrb;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m_mben) begin
      rd_m.push_back(m_maddr);
      rd_v.push_back(m_vaddr);
      if (!m_vben || m_vwe) bad++;
    end
    if (m_vwe) begin
      wr_a.push_back(m_vaddr);
      wr_c.push_back(cyc - c0);
      if (m_mben || !m_vben) bad++;
    end
    if (!m_zero) begin
      if (m_last) last_idx.push_back(ndata);
      ndata++;
    end else if (m_last) begin
      bad++;
    end
    if (m_done) begin
      ndone++;
      done_c = cyc - c0;
    end
    if (m_busy) busy_seen = 1'b1;
    if (m_mben || m_vben) en_seen = 1'b1;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_m.delete(); rd_v.delete(); wr_a.delete(); wr_c.delete();
    last_idx.delete();
    ndata = 0; ndone = 0; done_c = -1; bad = 0;
    busy_seen = 1'b0; en_seen = 1'b0;
  endtask

  task automatic go(input bit s, input int r, input int c);
    sel = s;
    clear_mon();
    @(posedge clk); #1;
    c0 = cyc;
    rows = DW'(r);
    cols = DW'(c);
    if (s) start1 = 1'b1;
    else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Cycle schedule: one tile per cycle unless a result write owns the port.
  task automatic build_model(input int r, input int c, input int d);
    int sched[$];
    int nxt;
    int cy;
    exp_tpr = (c + 5) / 6;
    exp_nrb = (r + 5) / 6;
    exp_t = exp_tpr * exp_nrb;
    exp_wc.delete();
    exp_stalls = 0;
    nxt = 0;
    cy = 1;
    while (nxt < exp_t || sched.size() > 0) begin
      if (sched.size() > 0 && sched[0] == cy) begin
        exp_wc.push_back(cy);
        void'(sched.pop_front());
        if (nxt < exp_t) exp_stalls++;
      end else if (nxt < exp_t) begin
        if (nxt % exp_tpr == exp_tpr - 1) sched.push_back(cy + 2 + d);
        nxt++;
      end
      cy++;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (ndone == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_within_budget", ndone > 0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag);
    int errs;
    chk({tag, "_reads"}, rd_m.size(), exp_t);
    errs = 0;
    foreach (rd_m[i])
      if (rd_m[i] != MW'(i) || rd_v[i] != VW'(i % exp_tpr)) errs++;
    chk({tag, "_read_seq_errs"}, errs, 0);
    chk({tag, "_data_cycles"}, ndata, exp_t);
    errs = 0;
    if (last_idx.size() != exp_nrb) errs++;
    else foreach (last_idx[i]) if (last_idx[i] != (i + 1) * exp_tpr - 1) errs++;
    chk({tag, "_last_pos_errs"}, errs, 0);
    chk({tag, "_writes"}, wr_a.size(), exp_nrb);
    errs = 0;
    foreach (wr_a[i]) if (wr_a[i] != VW'(512 + i)) errs++;
    chk({tag, "_wr_addr_errs"}, errs, 0);
    errs = 0;
    if (wr_c.size() != exp_wc.size()) errs++;
    else foreach (wr_c[i]) if (wr_c[i] != exp_wc[i]) errs++;
    chk({tag, "_wr_cycle_errs"}, errs, 0);
    chk({tag, "_done_count"}, ndone, 1);
    if (exp_wc.size() > 0) chk({tag, "_done_cycle"}, done_c, exp_wc[$] + 1);
    chk({tag, "_port_errs"}, bad, 0);
  endtask

  initial begin
    int r, c;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags",
        {busy0, done0, mben0, vben0, vwe0, zero0, last0, rd0}, 8'b0000_0100);
    chk("reset_maddr", maddr0, 0);
    chk("reset_vaddr", vaddr0, 0);
    rst = 1'b0;

    go(1'b0, 13, 13);
    build_model(13, 13, 84);
    wait_done(400);
    verify("sq13");
    chk("sq13_done_abs", done_c, 96);
`ifdef MVC_PERF_EN
    chk("sq13_perf_cycles", pc0, 9 + 84 + 3);
    chk("sq13_perf_stalls", ps0, 0);
`endif

    go(1'b1, 60, 6);
    build_model(60, 6, 4);
    wait_done(300);
    verify("tall60");
`ifdef MVC_PERF_EN
    chk("tall60_perf_stalls", ps1, exp_stalls);
`endif

    go(1'b0, 5, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("zdim_done_count", ndone, 1);
    chk("zdim_done_cycle", done_c, 1);
    chk("zdim_busy_seen", busy_seen, 0);
    chk("zdim_en_seen", en_seen, 0);

    go(1'b0, 13, 13);
    repeat (4) @(posedge clk);
    #1;
    abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    chk("abort_busy_next", busy0, 0);
    chk("abort_mben_next", mben0, 0);
    repeat (120) @(posedge clk);
    #1;
    chk("abort_reads", rd_m.size(), 5);
    chk("abort_writes", wr_a.size(), 0);
    chk("abort_done", ndone, 0);

    go(1'b0, 13, 13);
    build_model(13, 13, 84);
    wait_done(400);
    verify("post_abort");

    go(1'b1, 20, 14);
    repeat (2) @(posedge clk);
    #1;
    rows = DW'(3);
    cols = DW'(3);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    build_model(20, 14, 4);
    wait_done(300);
    verify("restart_ignored");

    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(1, 40);
      c = $urandom_range(1, 40);
      go(1'b1, r, c);
      build_model(r, c, 4);
      wait_done(600);
      verify($sformatf("rnd%0d_%0dx%0d", k, r, c));
    end

    go(1'b0, 13, 13);
    repeat (50) @(posedge clk);
    #3;
    chk("drain_busy_before_rst", busy0, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_flags",
        {busy0, done0, mben0, vben0, vwe0, zero0, last0, rd0}, 8'b0000_0100);
    chk("rst_mid_maddr", maddr0, 0);
    chk("rst_mid_vaddr", vaddr0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("rst_mid_no_write", wr_a.size(), 0);
    chk("rst_mid_no_done", ndone, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
